tt_um_i2c_7seg: RTL and testbench
=================================

// Module: tt_um_i2c_7seg
// PURPOSE
//  TinyTapeout top: I2C target (slave) holding one 8-bit display register.
//  Register drives a 7-segment display plus decimal point on uo_out.
//  Master writes the register and reads it back over a standard 2-wire bus.
//  SCL in on ui_in[0]; SDA bidirectional on uio[0], open-drain.
// PARAMETERS
//  I2C_ADDR  7'h2A  7-bit target address this block responds to
// PORTS
//  clk      in   1  system clock, >= 10x SCL rate; only clock
//  rst_n    in   1  reset, asynchronous, active-high (1 = reset)
//  ena      in   1  tile enable; ignored, design always active
//  ui_in    in   8  [0]=SCL; [7:1] unused
//  uo_out   out  8  [6:0]=segments a..g (=disp_reg[6:0]); [7]=dp (=disp_reg[7])
//  uio_in   in   8  [0]=SDA in; [7:1] unused
//  uio_out  out  8  all bits constant 0 (open-drain low level)
//  uio_oe   out  8  [0]=1 pulls SDA low; [7:1]=0
// BEHAVIOUR
//  Reset: disp_reg=8'h00, uo_out=0, uio_out=0, uio_oe=0, FSM=IDLE, counters 0.
//  Sync: SCL, SDA through 2-FF synchronizers; edges from 3rd-stage compare.
//  START: SDA falls while SCL high -> FSM=ADDR, bit count 0, from any state
//   (repeated START included). STOP: SDA rises while SCL high -> IDLE,
//   uio_oe[0]=0.
//  Bits sampled on SCL rising edge, MSB first; SDA driven changes only
//   after SCL falling edge.
//  States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
//  ADDR: shift 8 bits; on 8th rising edge: addr==I2C_ADDR -> ADDR_ACK, else
//   IGNORE (no SDA drive until next START/STOP).
//  ADDR_ACK: oe=1 from 8th SCL fall through 9th SCL fall; then R/W=0 ->
//   WRITE, R/W=1 -> READ (shift register loaded from disp_reg).
//  WRITE: shift 8 bits; on 8th rising edge disp_reg<=byte (segments update
//   within 1 clk); -> WRITE_ACK (ACK driven as above) -> WRITE. Unlimited
//   bytes; each overwrites disp_reg.
//  READ: drive bit MSB first: oe=~bit, set on each SCL fall; after 8 bits
//   release SDA -> READ_ACK: sample master ACK on 9th rising edge; ACK(0)
//   -> reload disp_reg, READ again; NACK(1) -> IGNORE until STOP/START.
//  Target never stretches SCL; uio_out stays 0 always (open-drain).
//  Reset mid-transfer: all state cleared immediately, SDA released.
//  Glitches shorter than 2 clk may be missed; no filtering beyond sync.
// TESTING
//  Reset, idle bus (SCL=SDA=1) -> uo_out=8'h00, uio_oe=8'h00.
//  START, 0x54(0x2A,W), 0x3F, STOP -> ACK both bytes (oe[0]=1 in 9th
//   clock), uo_out=8'h3F after 8th data bit.
//  START, 0x56 (addr 0x2B,W), 0xFF, STOP -> no ACK, uo_out unchanged.
//  After writing 0x06: START, 0x55(R), master NACK -> SDA reads 0x06.
//  Write 0x5B,0x4F in one transaction -> both ACKed, final uo_out=8'h4F.
//  Assert rst_n mid-byte -> uio_oe=0, uo_out=0, next START works normally.

Source files
------------

// File: rtl/tt_um_i2c_7seg.sv
// I2C target holding one display byte that drives a 7-segment digit plus decimal point.
// SCL/SDA are oversampled by clk; SDA is open-drain, so only uio_oe[0] ever pulls the line.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus free, waiting for START
// S_ADDR     | shifting in 7-bit address + R/W
// S_ADDR_ACK | address matched; ACK driven across the 9th clock
// S_WRITE    | shifting in a data byte for disp_reg
// S_WRITE_ACK| data byte stored; ACK driven across the 9th clock
// S_READ     | driving disp_reg out MSB first
// S_READ_ACK | SDA released; sampling master ACK/NACK on the 9th rise
// S_IGNORE   | not addressed or master NACKed; silent until START/STOP
module tt_um_i2c_7seg #(
    parameter logic [6:0] I2C_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK,
        S_IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] disp_q, disp_d;
    logic       oe_q, oe_d;
    logic       rw_q, rw_d;

    logic       scl_rise, scl_fall, scl_high;
    logic       start_det, stop_det;
    logic       sda_bit;
    logic [7:0] byte_in;

    logic       unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in[7:1]};

    // Stage [1] is the settled sample; stage [2] is its one-clk-old copy for edge detection.
    assign scl_sync_d = {scl_sync_q[1:0], ui_in[0]};
    assign sda_sync_d = {sda_sync_q[1:0], uio_in[0]};

    assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
    assign scl_high  =  scl_sync_q[1] &  scl_sync_q[2];
    assign start_det =  scl_high & ~sda_sync_q[1] &  sda_sync_q[2];
    assign stop_det  =  scl_high &  sda_sync_q[1] & ~sda_sync_q[2];
    assign sda_bit   =  sda_sync_q[1];
    assign byte_in   = {shift_q[6:0], sda_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        disp_d  = disp_q;
        oe_d    = oe_q;
        rw_d    = rw_q;

        if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (shift_q[6:0] == I2C_ADDR) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = sda_bit;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end

                // First fall after the 8th bit asserts ACK, the next one (9th) ends it.
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (rw_q) begin
                            state_d = S_READ;
                            cnt_d   = 4'd0;
                            oe_d    = ~disp_q[7];
                            shift_d = {disp_q[6:0], 1'b0};
                        end else begin
                            state_d = S_WRITE;
                            cnt_d   = 4'd0;
                            oe_d    = 1'b0;
                        end
                    end
                end

                S_WRITE: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            disp_d  = byte_in;
                            cnt_d   = 4'd0;
                            state_d = S_WRITE_ACK;
                        end
                    end
                end

                S_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_WRITE;
                        end
                    end
                end

                // shift_q[7] always holds the next bit to put on the bus.
                S_READ: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_READ_ACK;
                        end else begin
                            oe_d    = ~shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end

                // cnt_q==1 marks "master ACKed"; the next byte starts on the following fall.
                S_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_bit) begin
                            state_d = S_IGNORE;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        state_d = S_READ;
                        cnt_d   = 4'd0;
                        oe_d    = ~disp_q[7];
                        shift_d = {disp_q[6:0], 1'b0};
                    end
                end

                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    // Synchronizers reset to the idle-bus level so reset release never fakes a START.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            disp_q     <= 8'h00;
            oe_q       <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            disp_q     <= disp_d;
            oe_q       <= oe_d;
            rw_q       <= rw_d;
        end
    end

    assign uo_out  = disp_q;
    assign uio_out = 8'h00;
    assign uio_oe  = {7'b0, oe_q};

endmodule

// File: tb/tb_tt_um_i2c_7seg.sv
// Bench for tt_um_i2c_7seg: bit-banged I2C master, open-drain bus, and a byte-level register model.
module tb_tt_um_i2c_7seg;

    localparam int Q = 10;
    localparam logic [6:0] ADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       sda_bus;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] model_disp = 8'h00;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~uio_oe[0];
    assign ui_in   = {7'b0, scl_m};
    assign uio_in  = {7'b0, sda_bus};

    tt_um_i2c_7seg dut (
        .clk     (clk),
        .rst_n   (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b, output logic oe_seen);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b       = sda_bus;
        oe_seen = uio_oe[0];
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack, output logic oe_seen);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack, oe_seen);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic b, oe;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b, oe);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // Address phase + n data bytes; model: only a matching address ACKs and stores bytes.
    task automatic write_xfer(input logic [6:0] a, input int n, input logic [31:0] data, input bit do_stop);
        logic ack, oe;
        bit   hit;
        hit = (a == ADDR);
        i2c_start();
        send_byte({a, 1'b0}, ack, oe);
        check("w_addr_ack", ack, hit ? 0 : 1);
        check("w_addr_oe", oe, hit ? 1 : 0);
        for (int k = 0; k < n; k++) begin
            send_byte(data[8*k +: 8], ack, oe);
            if (hit) model_disp = data[8*k +: 8];
            check("w_data_ack", ack, hit ? 0 : 1);
            check("w_uo_out", uo_out, model_disp);
        end
        if (do_stop) i2c_stop();
    endtask

    // Master ACKs all but the last byte; an unaddressed target leaves SDA floating high.
    task automatic read_xfer(input logic [6:0] a, input int n, input bit do_stop);
        logic       ack, oe;
        logic [7:0] d;
        bit         hit;
        hit = (a == ADDR);
        i2c_start();
        send_byte({a, 1'b1}, ack, oe);
        check("r_addr_ack", ack, hit ? 0 : 1);
        for (int k = 0; k < n; k++) begin
            recv_byte((k == n - 1) || !hit, d);
            check("r_data", d, hit ? model_disp : 8'hFF);
            if (!hit) break;
        end
        check("r_oe_released", uio_oe, 8'h00);
        if (do_stop) i2c_stop();
    endtask

    initial begin
        logic       b, oe, ack;
        logic [6:0] a;
        logic [31:0] data;
        int         n;

        repeat (5) @(negedge clk);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_uo_out", uo_out, 8'h00);
        check("idle_uio_oe", uio_oe, 8'h00);
        check("idle_uio_out", uio_out, 8'h00);

        write_xfer(ADDR, 1, 32'h3F, 1);
        write_xfer(7'h2B, 1, 32'hFF, 1);
        check("wrong_addr_keep", uo_out, 8'h3F);
        write_xfer(ADDR, 1, 32'h06, 1);
        read_xfer(ADDR, 1, 1);
        write_xfer(ADDR, 2, 32'h4F5B, 1);
        check("two_byte_final", uo_out, 8'h4F);
        read_xfer(ADDR, 3, 1);
        write_xfer(ADDR, 1, 32'h80, 1);
        read_xfer(ADDR, 1, 1);

        for (int it = 0; it < 20; it++) begin
            a = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
            n = $urandom_range(1, 3);
            data = $urandom;
            if ($urandom_range(0, 1) == 1)
                write_xfer(a, n, data, $urandom_range(0, 1) == 1);
            else
                read_xfer(a, n, $urandom_range(0, 1) == 1);
        end
        i2c_stop();
        check("rand_uio_out", uio_out, 8'h00);

        // Reset while the target is actively pulling SDA during a read of 0x06.
        write_xfer(ADDR, 1, 32'h06, 1);
        i2c_start();
        send_byte({ADDR, 1'b1}, ack, oe);
        check("mid_addr_ack", ack, 0);
        recv_bit(b, oe);
        check("mid_bit7", b, 0);
        recv_bit(b, oe);
        check("mid_drive_oe", oe, 1);
        sda_m = 1'b1;
        scl_m = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_still_driving", uio_oe, 8'h01);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_oe", uio_oe, 8'h00);
        check("mid_rst_uo", uo_out, 8'h00);
        rst = 1'b0;
        model_disp = 8'h00;
        repeat (10) @(negedge clk);
        write_xfer(ADDR, 1, 32'h6D, 1);
        read_xfer(ADDR, 1, 1);
        check("final_uo_out", uo_out, 8'h6D);
        check("final_uio_oe", uio_oe, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
